// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if: bundle of the data and handshake signals around the N:1
// registered multiplexer.
//
//   data_in   : CHANNELS*WIDTH flattened producer words, channel i at [i*WIDTH +: WIDTH]
//   valid_in  : CHANNELS per-channel "word available" flags
//   pop       : CHANNELS one-hot grant, the channel's word is taken this cycle
//   data_out  : WIDTH registered selected word
//   valid_out : data_out holds an untransferred word
//   sel_out   : SEL_W index of the channel that supplied data_out
//   ready_in  : consumer accepts data_out this cycle
//
// master : producer/consumer side (drives data_in, valid_in, ready_in)
// slave  : multiplexer side
interface mux_rr_n_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       valid_in;
    logic [CHANNELS-1:0]       pop;
    logic [WIDTH-1:0]          data_out;
    logic                      valid_out;
    logic [SEL_W-1:0]          sel_out;
    logic                      ready_in;

    modport master (
        output data_in,
        output valid_in,
        output ready_in,
        input  pop,
        input  data_out,
        input  valid_out,
        input  sel_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  ready_in,
        output pop,
        output data_out,
        output valid_out,
        output sel_out
    );
endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n: CHANNELS:1 registered multiplexer with round-robin or
// fixed-priority arbitration and a single output register with valid/ready
// flow control.
//
//   clk     : single clock, all state on the rising edge
//   reset_L : synchronous active-low reset
//   bus     : mux_rr_n_if.slave (data_in, valid_in, pop, data_out,
//             valid_out, sel_out, ready_in)
//
// There is no FSM: the state is the output register (data/sel/valid) and
// the round-robin pointer.
module mux_rr_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter bit RR_MODE  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_L,
    mux_rr_n_if.slave  bus
);

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;
    logic [SEL_W-1:0] ptr_q;

    logic [SEL_W-1:0] eff_ptr;
    logic [SEL_W-1:0] win_hi;
    logic [SEL_W-1:0] win_lo;
    logic             found_hi;
    logic             found_lo;
    logic [SEL_W-1:0] win;
    logic             any_valid;
    logic             load;
    logic             do_load;
    logic [WIDTH-1:0] win_data;
    logic [SEL_W-1:0] ptr_next;

    // Fixed-priority mode is round-robin with the search always starting at 0.
    assign eff_ptr = RR_MODE ? ptr_q : '0;

    // Two-pass round-robin search: first the lowest valid channel at or above
    // the pointer; if none, wrap around and take the lowest valid channel.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.valid_in[c] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = SEL_W'(c);
            end
            if (bus.valid_in[c] && !found_hi && (SEL_W'(c) >= eff_ptr)) begin
                found_hi = 1'b1;
                win_hi   = SEL_W'(c);
            end
        end
    end

    assign win       = found_hi ? win_hi : win_lo;
    assign any_valid = found_lo;

    // The register may take a new word when empty or when its word leaves now.
    assign load    = !valid_q || bus.ready_in;
    assign do_load = reset_L && load && any_valid;

    always_comb begin
        win_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (win == SEL_W'(c)) begin
                win_data = bus.data_in[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.pop = '0;
        if (do_load) begin
            bus.pop[win] = 1'b1;
        end
    end

    // Explicit wrap so non-power-of-two channel counts never land on an
    // unused index.
    assign ptr_next = (win == SEL_W'(CHANNELS - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (do_load) begin
            data_q  <= win_data;
            sel_q   <= win;
            valid_q <= 1'b1;
            ptr_q   <= ptr_next;
        end else if (valid_q && bus.ready_in) begin
            // Word left with nothing to replace it; data/sel keep last values.
            valid_q <= 1'b0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.sel_out   = sel_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: drives three multiplexer instances (4ch round-robin,
// 4ch fixed priority, 3ch round-robin) with the same stimulus and compares
// every cycle against a behavioural model of the arbitration rules.
module tb_mux_rr_n;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mux_rr_n_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) if0 ();
    mux_rr_n_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) if1 ();
    mux_rr_n_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) if2 ();

    mux_rr_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .RR_MODE(1'b1)) dut_rr4 (
        .clk(clk), .reset_L(reset_L), .bus(if0));
    mux_rr_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .RR_MODE(1'b0)) dut_fp4 (
        .clk(clk), .reset_L(reset_L), .bus(if1));
    mux_rr_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .RR_MODE(1'b1)) dut_rr3 (
        .clk(clk), .reset_L(reset_L), .bus(if2));

    // Reference model state per instance.
    int         m_ptr  [3];
    logic [3:0] m_dout [3];
    bit         m_vout [3];
    int         m_sel  [3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int n_of(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    // Winner: scan n channels starting at ptr (round-robin) or at 0 (fixed).
    function automatic int pick(input logic [3:0] v, input int ptr, input int n, input bit rr);
        for (int i = 0; i < n; i++) begin
            int c;
            c = rr ? (ptr + i) % n : i;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k] = 0; m_dout[k] = 4'h0; m_vout[k] = 1'b0; m_sel[k] = 0;
        end
    endfunction

    // Apply one cycle of stimulus, check all instances at the falling edge,
    // advance the model, and return just after the next rising edge.
    task automatic run_cycle(input logic [15:0] d, input logic [3:0] v,
                             input logic rdy, input logic rst_n);
        logic [3:0] o_pop  [3];
        logic [3:0] o_dout [3];
        logic       o_vout [3];
        logic [1:0] o_sel  [3];
        if0.data_in = d;        if1.data_in = d;        if2.data_in = d[11:0];
        if0.valid_in = v;       if1.valid_in = v;       if2.valid_in = v[2:0];
        if0.ready_in = rdy;     if1.ready_in = rdy;     if2.ready_in = rdy;
        reset_L = rst_n;
        @(negedge clk);
        o_pop[0] = if0.pop;           o_pop[1] = if1.pop;           o_pop[2] = {1'b0, if2.pop};
        o_dout[0] = if0.data_out;     o_dout[1] = if1.data_out;     o_dout[2] = if2.data_out;
        o_vout[0] = if0.valid_out;    o_vout[1] = if1.valid_out;    o_vout[2] = if2.valid_out;
        o_sel[0] = if0.sel_out;       o_sel[1] = if1.sel_out;       o_sel[2] = if2.sel_out;
        for (int k = 0; k < 3; k++) begin
            int         n;
            int         g;
            bit         rr;
            bit         ld;
            logic [3:0] vm;
            logic [3:0] e_pop;
            n  = n_of(k);
            rr = (k != 1);
            vm = v;
            if (n == 3) vm[3] = 1'b0;
            ld = !m_vout[k] || rdy;
            g  = pick(vm, m_ptr[k], n, rr);
            e_pop = (rst_n && ld && g >= 0) ? 4'(1 << g) : 4'h0;
            check_val($sformatf("pop%0d", k), 32'(o_pop[k]), 32'(e_pop));
            check_val($sformatf("valid_out%0d", k), 32'(o_vout[k]), 32'(m_vout[k]));
            check_val($sformatf("data_out%0d", k), 32'(o_dout[k]), 32'(m_dout[k]));
            check_val($sformatf("sel_out%0d", k), 32'(o_sel[k]), 32'(m_sel[k]));
            if (!rst_n) begin
                m_ptr[k] = 0; m_dout[k] = 4'h0; m_vout[k] = 1'b0; m_sel[k] = 0;
            end else if (ld && g >= 0) begin
                m_dout[k] = d[g*4 +: 4];
                m_sel[k]  = g;
                m_vout[k] = 1'b1;
                m_ptr[k]  = (g + 1) % n;
            end else if (m_vout[k] && rdy) begin
                m_vout[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        if0.data_in = '0; if1.data_in = '0; if2.data_in = '0;
        if0.valid_in = '0; if1.valid_in = '0; if2.valid_in = '0;
        if0.ready_in = 1'b1; if1.ready_in = 1'b1; if2.ready_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset held with every channel valid: no grants, outputs cleared.
        repeat (2) run_cycle(16'hDCBA, 4'hF, 1'b1, 1'b0);

        // Full load after release: strict rotation, no bubbles.
        for (int i = 0; i < 8; i++) begin
            run_cycle(16'hDCBA, 4'hF, 1'b1, 1'b1);
            check_val("rr4_seq", 32'(if0.sel_out), 32'(i % 4));
            check_val("rr4_data", 32'(if0.data_out), 32'(4'hA + i % 4));
            check_val("rr4_valid", 32'(if0.valid_out), 32'd1);
            check_val("fp4_seq", 32'(if1.sel_out), 32'd0);
            check_val("rr3_seq", 32'(if2.sel_out), 32'(i % 3));
        end

        // Sparse valid from pointer 0: ch1, ch3, ch1.
        run_cycle(16'h0000, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(16'h5678, 4'b1010, 1'b1, 1'b1);
            check_val("sparse_sel", 32'(if0.sel_out), (i == 1) ? 32'd3 : 32'd1);
        end

        // Backpressure for three cycles, then release.
        repeat (3) run_cycle(16'h1234, 4'hF, 1'b0, 1'b1);
        check_val("stall_sel", 32'(if0.sel_out), 32'd1);
        run_cycle(16'h1234, 4'hF, 1'b1, 1'b1);
        check_val("resume_sel", 32'(if0.sel_out), 32'd2);

        // Fixed priority with upper channels only.
        run_cycle(16'h9ABC, 4'b1100, 1'b1, 1'b1);
        check_val("fp4_1100", 32'(if1.sel_out), 32'd2);

        // Mid-stream reset, then first grant goes back to channel 0.
        run_cycle(16'hDCBA, 4'hF, 1'b1, 1'b0);
        check_val("midrst_valid", 32'(if2.valid_out), 32'd0);
        run_cycle(16'hDCBA, 4'hF, 1'b1, 1'b1);
        check_val("midrst_sel", 32'(if2.sel_out), 32'd0);

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 500; i++) begin
            logic [15:0] d;
            logic [3:0]  v;
            logic        rdy;
            logic        rst_n;
            d     = 16'($urandom);
            v     = 4'($urandom_range(0, 15));
            rdy   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 59) != 0);
            run_cycle(d, v, rdy, rst_n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
